// File: rtl/dmem_copy_engine_if.sv
// Data-memory request/response bundle between a requester and the test memory.
// Read data is combinational in the request cycle; writes commit on the clock edge.
interface dmem_copy_engine_if;
   logic        dmemreq_val;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic [31:0] dmemresp_rdata;

   modport master (
      output dmemreq_val,
      output dmemreq_type,
      output dmemreq_addr,
      output dmemreq_wdata,
      input  dmemresp_rdata
   );

   modport slave (
      input  dmemreq_val,
      input  dmemreq_type,
      input  dmemreq_addr,
      input  dmemreq_wdata,
      output dmemresp_rdata
   );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-by-word block copy over the dmem port: one read then one write per word,
// ascending addresses, with a one-cycle done pulse at the end.
module dmem_copy_engine #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [31:0]          src_addr_i,
   input  logic [31:0]          dst_addr_i,
   input  logic [CNT_W-1:0]     num_words_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_W-1:0]     words_copied_o,
   dmem_copy_engine_if.master   dmem
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    copied_q, copied_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                val_q, val_d;
   logic                type_q, type_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      src_ptr_d = src_ptr_q;
      dst_ptr_d = dst_ptr_q;
      rem_d     = rem_q;
      data_d    = data_q;
      copied_d  = copied_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               src_ptr_d = src_addr_i;
               dst_ptr_d = dst_addr_i;
               rem_d     = num_words_i;
               copied_d  = '0;
               state_d   = (num_words_i == '0) ? DONE : READ;
            end
         end
         READ: begin
            data_d    = dmem.dmemresp_rdata;
            src_ptr_d = src_ptr_q + ADDR_W'(4);
            state_d   = WRITE;
         end
         WRITE: begin
            dst_ptr_d = dst_ptr_q + ADDR_W'(4);
            rem_d     = rem_q - CNT_W'(1);
            copied_d  = copied_q + CNT_W'(1);
            state_d   = (rem_q == CNT_W'(1)) ? DONE : READ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs precomputed from the next state so they leave a register
   always_comb begin
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      val_d   = 1'b0;
      type_d  = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      unique case (state_d)
         READ: begin
            val_d  = 1'b1;
            addr_d = src_ptr_d;
         end
         WRITE: begin
            val_d   = 1'b1;
            type_d  = 1'b1;
            addr_d  = dst_ptr_d;
            wdata_d = data_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         copied_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         val_q     <= 1'b0;
         type_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         src_ptr_q <= src_ptr_d;
         dst_ptr_q <= dst_ptr_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         copied_q  <= copied_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         val_q     <= val_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign words_copied_o     = copied_q;
   assign dmem.dmemreq_val   = val_q;
   assign dmem.dmemreq_type  = type_q;
   assign dmem.dmemreq_addr  = addr_q;
   assign dmem.dmemreq_wdata = wdata_q;

endmodule
